csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_unit_if.sv | 30 +++
 rtl/csr_unit.sv | 182 ++++++++++++++++++
 tb/tb_csr_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/csr_unit_if.sv
// ============================================================================
//  Module      : csr_unit_if
//  Description : CSR access bus between decode (master) and csr_unit (slave).
//                Carries the read/write request, the operand and the
//                combinational read data/fault response.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface csr_unit_if;
  logic        CSR_reg_rd;
  logic        CSR_reg_wr;
  logic [1:0]  CSR_wd_select;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        illegal_csr;

  modport master (
    output CSR_reg_rd, CSR_reg_wr, CSR_wd_select, csr_addr, csr_wdata,
    input  csr_rdata, illegal_csr
  );

  modport slave (
    input  CSR_reg_rd, CSR_reg_wr, CSR_wd_select, csr_addr, csr_wdata,
    output csr_rdata, illegal_csr
  );
endinterface

`default_nettype wire

// File: rtl/csr_unit.sv
// ============================================================================
//  Module      : csr_unit
//  Description : Machine-mode CSR file: mstatus, mtvec, mscratch, mepc,
//                mcause, mhartid, with trap entry / mret handling.
//                Optional macro CSR_COUNTERS_EN adds 64-bit mcycle and
//                minstret counters (0xB00/0xB80, 0xB02/0xB82).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  wire         clk,
  input  wire         rst,
  csr_unit_if.slave   bus,
  input  wire         instr_retire,
  input  wire         trap_req,
  input  wire  [31:0] trap_cause,
  input  wire  [31:0] trap_pc,
  input  wire         mret,
  output logic [31:0] trap_vector,
  output logic [31:0] epc_out
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH= 12'hB82;

  // Only MIE (bit 3) and MPIE (bit 7) are writable; MPP reads as 11.
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;

  logic [31:0] mstatus_q;   // holds only the writable bits
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;

  logic [31:0] mstatus_val;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        implemented;
  logic        wr_effective;
  logic        illegal;
  logic        do_write;
  logic        mie_bit;
  logic        mpie_bit;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;
`endif

  assign mstatus_val = mstatus_q | MSTATUS_FIXED;
  assign mie_bit     = mstatus_q[3];
  assign mpie_bit    = mstatus_q[7];

  // Address decode: select the pre-update value and flag unknown addresses.
  always_comb begin
    implemented = 1'b1;
    old_val     = 32'h0;
    case (bus.csr_addr)
      ADDR_MSTATUS:   old_val = mstatus_val;
      ADDR_MTVEC:     old_val = mtvec_q;
      ADDR_MSCRATCH:  old_val = mscratch_q;
      ADDR_MEPC:      old_val = mepc_q;
      ADDR_MCAUSE:    old_val = mcause_q;
      ADDR_MHARTID:   old_val = HART_ID;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE:    old_val = mcycle_q[31:0];
      ADDR_MCYCLEH:   old_val = mcycle_q[63:32];
      ADDR_MINSTRET:  old_val = minstret_q[31:0];
      ADDR_MINSTRETH: old_val = minstret_q[63:32];
`endif
      default:        implemented = 1'b0;
    endcase
  end

  // Read-modify-write operand selection.
  always_comb begin
    new_val = old_val;
    case (bus.CSR_wd_select)
      2'b00:   new_val = bus.csr_wdata;
      2'b01:   new_val = old_val | bus.csr_wdata;
      2'b10:   new_val = old_val & ~bus.csr_wdata;
      default: new_val = old_val;
    endcase
  end

  // Address bits [11:10] == 11 mark the read-only CSR space.
  assign wr_effective = bus.CSR_reg_wr && (bus.CSR_wd_select != 2'b11);
  assign illegal      = (bus.CSR_reg_rd || bus.CSR_reg_wr) &&
                        (!implemented ||
                         (wr_effective && (bus.csr_addr[11:10] == 2'b11)));
  assign do_write     = wr_effective && !illegal;

  assign bus.csr_rdata   = bus.CSR_reg_rd ? old_val : 32'h0;
  assign bus.illegal_csr = illegal;
  assign trap_vector     = mtvec_q;
  assign epc_out         = mepc_q;

  // mstatus: trap entry beats mret, which beats a software write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mstatus_q <= 32'h0;
    end else if (trap_req) begin
      mstatus_q <= {24'h0, mie_bit, 3'b000, 1'b0, 3'b000};
    end else if (mret) begin
      mstatus_q <= {24'h0, 1'b1, 3'b000, mpie_bit, 3'b000};
    end else if (do_write && bus.csr_addr == ADDR_MSTATUS) begin
      mstatus_q <= new_val & MSTATUS_WMASK;
    end
  end

  // mepc/mcause: trap entry drops any same-cycle software write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mepc_q   <= 32'h0;
      mcause_q <= 32'h0;
    end else if (trap_req) begin
      mepc_q   <= trap_pc & ~32'h3;
      mcause_q <= trap_cause;
    end else begin
      if (do_write && bus.csr_addr == ADDR_MEPC)   mepc_q   <= new_val & ~32'h3;
      if (do_write && bus.csr_addr == ADDR_MCAUSE) mcause_q <= new_val;
    end
  end

  // mtvec/mscratch are untouched by trap/mret, so writes always land.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mtvec_q    <= MTVEC_RESET & ~32'h3;
      mscratch_q <= 32'h0;
    end else begin
      if (do_write && bus.csr_addr == ADDR_MTVEC)    mtvec_q    <= new_val & ~32'h3;
      if (do_write && bus.csr_addr == ADDR_MSCRATCH) mscratch_q <= new_val;
    end
  end

`ifdef CSR_COUNTERS_EN
  // mcycle: a write to either half freezes the other half for that cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mcycle_q <= 64'h0;
    end else if (do_write && bus.csr_addr == ADDR_MCYCLE) begin
      mcycle_q[31:0] <= new_val;
    end else if (do_write && bus.csr_addr == ADDR_MCYCLEH) begin
      mcycle_q[63:32] <= new_val;
    end else begin
      mcycle_q <= mcycle_q + 64'd1;
    end
  end

  // minstret: same write precedence, increments only on retirement.
  always_ff @(posedge clk) begin
    if (!rst) begin
      minstret_q <= 64'h0;
    end else if (do_write && bus.csr_addr == ADDR_MINSTRET) begin
      minstret_q[31:0] <= new_val;
    end else if (do_write && bus.csr_addr == ADDR_MINSTRETH) begin
      minstret_q[63:32] <= new_val;
    end else if (instr_retire) begin
      minstret_q <= minstret_q + 64'd1;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
`endif

endmodule

`default_nettype wire

// File: tb/tb_csr_unit.sv
// ============================================================================
//  Module      : tb_csr_unit
//  Description : Directed self-checking bench for csr_unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_csr_unit;
  localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
  localparam logic [31:0] HART      = 32'h0000_0005;

  logic        clk;
  logic        rst;
  logic        instr_retire;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret;
  logic [31:0] trap_vector;
  logic [31:0] epc_out;

  int vec_count;
  int err_count;

  csr_unit_if bus ();

  csr_unit #(.MTVEC_RESET(MTVEC_RST), .HART_ID(HART)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .instr_retire (instr_retire),
    .trap_req     (trap_req),
    .trap_cause   (trap_cause),
    .trap_pc      (trap_pc),
    .mret         (mret),
    .trap_vector  (trap_vector),
    .epc_out      (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec_count++;
    if (obs !== expv) begin
      err_count++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_read(input string tag, input logic [11:0] addr, input logic [31:0] expv);
    bus.CSR_reg_rd = 1'b1;
    bus.csr_addr   = addr;
    #1;
    check(tag, bus.csr_rdata, expv);
    check({tag, "_ill"}, {31'h0, bus.illegal_csr}, 32'h0);
    bus.CSR_reg_rd = 1'b0;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [1:0] sel, input logic [31:0] data);
    bus.CSR_reg_wr    = 1'b1;
    bus.CSR_wd_select = sel;
    bus.csr_addr      = addr;
    bus.csr_wdata     = data;
    tick();
    bus.CSR_reg_wr    = 1'b0;
    bus.CSR_wd_select = 2'b11;
  endtask

  task automatic check_illegal(input string tag, input logic rd, input logic wr,
                               input logic [1:0] sel, input logic [11:0] addr,
                               input logic expv);
    bus.CSR_reg_rd    = rd;
    bus.CSR_reg_wr    = wr;
    bus.CSR_wd_select = sel;
    bus.csr_addr      = addr;
    bus.csr_wdata     = 32'hFFFF_FFFF;
    #1;
    check(tag, {31'h0, bus.illegal_csr}, {31'h0, expv});
    tick();
    bus.CSR_reg_rd    = 1'b0;
    bus.CSR_reg_wr    = 1'b0;
    bus.CSR_wd_select = 2'b11;
  endtask

  initial begin
    vec_count = 0;
    err_count = 0;
    bus.CSR_reg_rd    = 1'b0;
    bus.CSR_reg_wr    = 1'b0;
    bus.CSR_wd_select = 2'b11;
    bus.csr_addr      = 12'h0;
    bus.csr_wdata     = 32'h0;
    instr_retire      = 1'b0;
    trap_cause        = 32'h1234_5678;
    trap_pc           = 32'h0000_0ABC;
    mret              = 1'b0;
    // Trap held during reset must be overridden.
    trap_req          = 1'b1;
    rst               = 1'b0;
    tick();
    tick();
    trap_req = 1'b0;
    rst      = 1'b1;

    // Reset state
    check("rst_tvec", trap_vector, 32'h0000_1000);
    check("rst_epc", epc_out, 32'h0);
    csr_read("rst_mstatus", 12'h300, 32'h0000_1800);
    csr_read("rst_mtvec", 12'h305, 32'h0000_1000);
    csr_read("rst_mscratch", 12'h340, 32'h0);
    csr_read("rst_mcause", 12'h342, 32'h0);

    // mtvec write, low bits forced to zero
    csr_write(12'h305, 2'b00, 32'h8000_0103);
    check("mtvec_tvec", trap_vector, 32'h8000_0100);
    csr_read("mtvec_rd", 12'h305, 32'h8000_0100);

    // mscratch write / set / clear / no-modify
    csr_write(12'h340, 2'b00, 32'hA5A5_0000);
    csr_read("scr_wr", 12'h340, 32'hA5A5_0000);
    csr_write(12'h340, 2'b01, 32'h0000_00FF);
    csr_read("scr_set", 12'h340, 32'hA5A5_00FF);
    csr_write(12'h340, 2'b10, 32'hA500_000F);
    csr_read("scr_clr", 12'h340, 32'h00A5_00F0);
    csr_write(12'h340, 2'b11, 32'h0000_0000);
    csr_read("scr_nomod", 12'h340, 32'h00A5_00F0);

    // Read returns pre-update value in the write cycle
    bus.CSR_reg_rd = 1'b1;
    bus.CSR_reg_wr = 1'b1;
    bus.CSR_wd_select = 2'b00;
    bus.csr_addr   = 12'h340;
    bus.csr_wdata  = 32'h1111_2222;
    #1;
    check("rw_old", bus.csr_rdata, 32'h00A5_00F0);
    tick();
    bus.CSR_reg_wr = 1'b0;
    bus.CSR_wd_select = 2'b11;
    check("rw_new", bus.csr_rdata, 32'h1111_2222);
    bus.CSR_reg_rd = 1'b0;

    // mstatus: only MIE/MPIE writable
    csr_write(12'h300, 2'b00, 32'hFFFF_E77F);
    csr_read("mst_wr", 12'h300, 32'h0000_1808);
    csr_write(12'h300, 2'b10, 32'h0000_0008);
    csr_read("mst_clr", 12'h300, 32'h0000_1800);
    csr_write(12'h300, 2'b01, 32'h0000_0008);

    // mepc low bits read zero
    csr_write(12'h341, 2'b00, 32'h0000_1003);
    csr_read("mepc_wr", 12'h341, 32'h0000_1000);

    // Trap coinciding with an mepc write: write dropped
    trap_req   = 1'b1;
    trap_pc    = 32'h0000_0207;
    trap_cause = 32'h8000_0007;
    csr_write(12'h341, 2'b00, 32'h1234_5678);
    trap_req   = 1'b0;
    check("trap_epc", epc_out, 32'h0000_0204);
    csr_read("trap_mcause", 12'h342, 32'h8000_0007);
    csr_read("trap_mstatus", 12'h300, 32'h0000_1880);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    csr_read("mret_mstatus", 12'h300, 32'h0000_1888);

    // mret coinciding with an mstatus write: write dropped
    csr_write(12'h300, 2'b10, 32'h0000_0088);
    csr_read("mst_clr2", 12'h300, 32'h0000_1800);
    mret = 1'b1;
    csr_write(12'h300, 2'b01, 32'h0000_0008);
    mret = 1'b0;
    csr_read("mret_prio", 12'h300, 32'h0000_1880);

    // Access faults
    check_illegal("ill_wr_hartid", 1'b0, 1'b1, 2'b00, 12'hF14, 1'b1);
    csr_read("hartid", 12'hF14, HART);
    check_illegal("ill_rd_7c0", 1'b1, 1'b0, 2'b11, 12'h7C0, 1'b1);
    check_illegal("nomod_hartid", 1'b0, 1'b1, 2'b11, 12'hF14, 1'b0);
    check_illegal("ill_set_c00", 1'b0, 1'b1, 2'b01, 12'hC00, 1'b1);
    csr_read("ill_nochg", 12'h340, 32'h1111_2222);

`ifdef CSR_COUNTERS_EN
    csr_write(12'hB00, 2'b00, 32'hFFFF_FFFF);
    csr_write(12'hB80, 2'b00, 32'hFFFF_FFFF);
    csr_read("cyc_lo_max", 12'hB00, 32'hFFFF_FFFF);
    csr_read("cyc_hi_max", 12'hB80, 32'hFFFF_FFFF);
    tick();
    csr_read("cyc_lo_wrap", 12'hB00, 32'h0);
    csr_read("cyc_hi_wrap", 12'hB80, 32'h0);
    tick();
    csr_read("cyc_lo_one", 12'hB00, 32'h1);
    csr_read("cyc_hi_one", 12'hB80, 32'h0);
    instr_retire = 1'b1;
    repeat (5) tick();
    instr_retire = 1'b0;
    csr_read("instret_lo", 12'hB02, 32'h5);
    csr_read("instret_hi", 12'hB82, 32'h0);
`else
    check_illegal("ill_mcycle", 1'b1, 1'b0, 2'b11, 12'hB00, 1'b1);
    check_illegal("ill_mcycleh", 1'b1, 1'b0, 2'b11, 12'hB80, 1'b1);
    check_illegal("ill_minstret", 1'b0, 1'b1, 2'b00, 12'hB02, 1'b1);
    check_illegal("ill_minstreth", 1'b1, 1'b0, 2'b11, 12'hB82, 1'b1);
`endif

    // Reset in the middle of a trap
    csr_write(12'h300, 2'b01, 32'h0000_0008);
    trap_req   = 1'b1;
    trap_pc    = 32'h0000_0400;
    trap_cause = 32'h0000_000B;
    rst        = 1'b0;
    tick();
    trap_req   = 1'b0;
    rst        = 1'b1;
    csr_read("rst2_mstatus", 12'h300, 32'h0000_1800);
    csr_read("rst2_mepc", 12'h341, 32'h0);
    csr_read("rst2_mcause", 12'h342, 32'h0);
    check("rst2_tvec", trap_vector, 32'h0000_1000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

`default_nettype wire
